// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one word-wide RAM port between the instruction
// fetch and data requesters. Round-robin arbitration on ties, read-modify-write
// for sub-word stores, and a watchdog that aborts stalled RAM accesses.
module ram_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  // Instruction fetch requester
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  // Data requester
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  // RAM side
  input  logic        busy_o,
  input  logic [31:0] ramload,
  output logic        Ren,
  output logic        Wen,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StIfetch,
    StDread,
    StDwrite,
    StRmwRd,
    StRmwWr,
    StDone
  } state_e;

  // Watchdog compare value: abort on the busy cycle that would make the count reach TIMEOUT.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      r_state;
  logic        r_ren;
  logic        r_wen;
  logic [31:0] r_ramaddr;
  logic [31:0] r_ramstore;
  logic        r_i_ready;
  logic        r_d_ready;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_timeout_err;
  logic [15:0] r_wdog;
  logic        r_last_grant_d;  // 1: data was granted last, 0: instr
  logic        r_owner_d;       // 1: current access belongs to data requester
  logic [1:0]  r_lane;          // byte lane of the sub-word store
  logic        r_half;          // sub-word store is a halfword
  logic [15:0] r_wdata;         // sub-word store data, right-justified

  logic        w_dreq;
  logic        w_grant_d;
  logic [31:0] w_merged;
  logic        w_unused;

  // Fetch addresses are word-aligned by the port; low bits are intentionally dropped.
  assign w_unused = ^i_addr[1:0];

  // Data request pending and whether data wins arbitration this cycle.
  always_comb begin
    w_dreq    = d_ren | d_wen;
    w_grant_d = w_dreq & (~i_req | ~r_last_grant_d);
  end

  // Little-endian lane merge of the stored sub-word into the word read from RAM.
  always_comb begin
    w_merged = ramload;
    if (r_half) begin
      if (r_lane[1]) begin
        w_merged[31:16] = r_wdata;
      end else begin
        w_merged[15:0] = r_wdata;
      end
    end else begin
      case (r_lane)
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end
  end

  // Sequencer: arbitration, RAM strobes, result capture, watchdog and ready pulses.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state        <= StIdle;
      r_ren          <= 1'b0;
      r_wen          <= 1'b0;
      r_ramaddr      <= 32'h0;
      r_ramstore     <= 32'h0;
      r_i_ready      <= 1'b0;
      r_d_ready      <= 1'b0;
      r_i_rdata      <= 32'h0;
      r_d_rdata      <= 32'h0;
      r_timeout_err  <= 1'b0;
      r_wdog         <= 16'h0;
      r_last_grant_d <= 1'b0;
      r_owner_d      <= 1'b0;
      r_lane         <= 2'b00;
      r_half         <= 1'b0;
      r_wdata        <= 16'h0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_wdog <= 16'h0;
          if (w_grant_d) begin
            r_owner_d <= 1'b1;
            r_ramaddr <= {d_addr[31:2], 2'b00};
            r_lane    <= d_addr[1:0];
            r_half    <= d_size[0];
            r_wdata   <= d_wdata[15:0];
            if (d_wen) begin
              if (d_size[1]) begin
                r_ramstore <= d_wdata;
                r_wen      <= 1'b1;
                r_state    <= StDwrite;
              end else begin
                r_ren   <= 1'b1;
                r_state <= StRmwRd;
              end
            end else begin
              r_ren   <= 1'b1;
              r_state <= StDread;
            end
          end else if (i_req) begin
            r_owner_d <= 1'b0;
            r_ramaddr <= {i_addr[31:2], 2'b00};
            r_ren     <= 1'b1;
            r_state   <= StIfetch;
          end
        end

        StIfetch, StDread, StDwrite, StRmwRd, StRmwWr: begin
          if (!busy_o) begin
            r_wdog <= 16'h0;
            case (r_state)
              StIfetch: begin
                r_i_rdata <= ramload;
                r_ren     <= 1'b0;
                r_i_ready <= 1'b1;
                r_state   <= StDone;
              end
              StDread: begin
                r_d_rdata <= ramload;
                r_ren     <= 1'b0;
                r_d_ready <= 1'b1;
                r_state   <= StDone;
              end
              StDwrite: begin
                r_wen     <= 1'b0;
                r_d_ready <= 1'b1;
                r_state   <= StDone;
              end
              StRmwRd: begin
                r_ramstore <= w_merged;
                r_ren      <= 1'b0;
                r_wen      <= 1'b1;
                r_state    <= StRmwWr;
              end
              default: begin
                r_d_rdata <= r_ramstore;
                r_wen     <= 1'b0;
                r_d_ready <= 1'b1;
                r_state   <= StDone;
              end
            endcase
          end else if (r_wdog == TimeoutLast) begin
            // Stalled too long: abandon the access, still hand the owner a ready.
            r_ren         <= 1'b0;
            r_wen         <= 1'b0;
            r_timeout_err <= 1'b1;
            if (r_owner_d) begin
              r_d_rdata <= 32'h0;
              r_d_ready <= 1'b1;
            end else begin
              r_i_rdata <= 32'h0;
              r_i_ready <= 1'b1;
            end
            r_state <= StDone;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end

        StDone: begin
          r_last_grant_d <= r_owner_d;
          r_state        <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Output drive: every output is a register.
  always_comb begin
    Ren         = r_ren;
    Wen         = r_wen;
    ramaddr     = r_ramaddr;
    ramstore    = r_ramstore;
    i_ready     = r_i_ready;
    d_ready     = r_d_ready;
    i_rdata     = r_i_rdata;
    d_rdata     = r_d_rdata;
    timeout_err = r_timeout_err;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: scoreboard of expected ready and
// write events, RAM wait-state responder, latency and boundary checks.
module tb_ram_port_arbiter;

  localparam int unsigned TO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_ren;
  logic        d_wen;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        busy_o;
  logic [31:0] ramload;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        timeout_err;

  ram_port_arbiter #(.TIMEOUT(TO)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ready    (i_ready),
    .i_rdata    (i_rdata),
    .d_ren      (d_ren),
    .d_wen      (d_wen),
    .d_size     (d_size),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ready    (d_ready),
    .d_rdata    (d_rdata),
    .busy_o     (busy_o),
    .ramload    (ramload),
    .Ren        (Ren),
    .Wen        (Wen),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  // RAM responder: cfg_wait busy cycles at the start of every strobe phase.
  int unsigned cfg_wait = 0;
  bit          stuck = 1'b0;
  int unsigned wait_cnt = 0;

  always @(posedge CLK) begin
    if (!(Ren || Wen) || !busy_o) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  assign busy_o = stuck || ((Ren || Wen) && (wait_cnt < cfg_wait));

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] rdata;
    bit          chk;
  } rdy_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  rdy_t        rdy_q[$];
  wr_t         wr_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_ready = 0;
  logic [31:0] exp_addr = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_model(input logic [31:0] load, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] mask;
    int          sh;
    mask = size[0] ? 32'h0000FFFF : 32'h000000FF;
    sh   = size[0] ? (addr[1] ? 16 : 0) : 8 * int'(addr[1:0]);
    return (load & ~(mask << sh)) | ((wdata & mask) << sh);
  endfunction

  // Monitor: strobe/address stability, write completions and ready pulses.
  always @(negedge CLK) begin
    rdy_t e;
    wr_t  w;
    if ((Ren || Wen) === 1'b1) begin
      check_eq("strobe_excl", {31'b0, Ren & Wen}, 32'h0);
      check_eq("ramaddr_stable", ramaddr, exp_addr);
    end
    if ((Wen && !busy_o) === 1'b1) begin
      check_eq("write_expected", {31'b0, wr_q.size() != 0}, 32'h1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        check_eq("write_addr", ramaddr, w.addr);
        check_eq("write_data", ramstore, w.data);
      end
    end
    if ((i_ready || d_ready) === 1'b1) begin
      n_ready++;
      check_eq("ready_expected", {31'b0, rdy_q.size() != 0}, 32'h1);
      if (rdy_q.size() != 0) begin
        e = rdy_q.pop_front();
        check_eq("ready_owner", {30'b0, i_ready, d_ready}, e.is_d ? 32'h1 : 32'h2);
        check_eq("ready_ramaddr", ramaddr, e.addr);
        check_eq("strobes_in_done", {30'b0, Ren, Wen}, 32'h0);
        if (e.chk) check_eq("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  task automatic drop_reqs();
    i_req = 1'b0;
    d_ren = 1'b0;
    d_wen = 1'b0;
    stuck = 1'b0;
  endtask

  // One transaction from the IDLE cycle; pushes expectations and checks latency.
  task automatic do_txn(input bit is_d, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] load, input int unsigned wt, input bit abort,
                        input string tag);
    rdy_t        e;
    wr_t         w;
    int unsigned lat;
    int          start;
    int          k;
    bit          rmw;
    rmw     = is_d && wr && !size[1];
    e.is_d  = is_d;
    e.addr  = {addr[31:2], 2'b00};
    e.chk   = 1'b1;
    e.rdata = load;
    w.addr  = e.addr;
    if (abort) begin
      lat     = 1 + TO;
      e.rdata = 32'h0;
    end else if (rmw) begin
      lat     = 3 + 2 * wt;
      e.rdata = merge_model(load, wdata, size, addr);
      w.data  = e.rdata;
      wr_q.push_back(w);
    end else if (wr) begin
      lat    = 2 + wt;
      e.chk  = 1'b0;
      w.data = wdata;
      wr_q.push_back(w);
    end else begin
      lat = 2 + wt;
    end
    rdy_q.push_back(e);
    cfg_wait = wt;
    ramload  = load;
    exp_addr = e.addr;
    stuck    = abort;
    if (is_d) begin
      d_ren   = !wr;
      d_wen   = wr;
      d_size  = size;
      d_addr  = addr;
      d_wdata = wdata;
    end else begin
      i_req  = 1'b1;
      i_addr = addr;
    end
    start = n_ready;
    k     = 0;
    while (n_ready == start && k < 50) begin
      @(negedge CLK);
      #1;
      k++;
    end
    check_eq({tag, "_latency"}, 32'(k), 32'(lat));
    drop_reqs();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    rdy_t        e;
    wr_t         w;
    int          k;
    int          start;
    logic [1:0]  rsz;
    logic [31:0] raddr;

    nRST    = 1'b0;
    i_req   = 1'b1;
    i_addr  = 32'h103;
    d_ren   = 1'b0;
    d_wen   = 1'b0;
    d_size  = 2'd0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    ramload = 32'h0;

    // Reset with a fetch request pending: every output must be zero.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_Ren", {31'b0, Ren}, 32'h0);
    check_eq("rst_Wen", {31'b0, Wen}, 32'h0);
    check_eq("rst_ramaddr", ramaddr, 32'h0);
    check_eq("rst_ramstore", ramstore, 32'h0);
    check_eq("rst_i_ready", {31'b0, i_ready}, 32'h0);
    check_eq("rst_d_ready", {31'b0, d_ready}, 32'h0);
    check_eq("rst_i_rdata", i_rdata, 32'h0);
    check_eq("rst_d_rdata", d_rdata, 32'h0);
    check_eq("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
    #1;
    nRST = 1'b1;
    do_txn(1'b0, 1'b0, 2'd0, 32'h103, 32'h0, 32'h00500093, 0, 1'b0, "fetch_after_rst");

    // Tie: all requests held; grants must alternate starting with data.
    ramload  = 32'h0BADF00D;
    cfg_wait = 0;
    exp_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      e.is_d  = (i % 2 == 0);
      e.addr  = 32'h300;
      e.rdata = 32'h0BADF00D;
      e.chk   = !e.is_d;
      rdy_q.push_back(e);
      if (e.is_d) begin
        w.addr = 32'h300;
        w.data = 32'h5A5A1234;
        wr_q.push_back(w);
      end
    end
    i_req   = 1'b1;
    i_addr  = 32'h301;
    d_ren   = 1'b1;
    d_wen   = 1'b1;
    d_size  = 2'd2;
    d_addr  = 32'h302;
    d_wdata = 32'h5A5A1234;
    start   = n_ready;
    k       = 0;
    while (n_ready < start + 4 && k < 100) begin
      @(negedge CLK);
      #1;
      k++;
    end
    check_eq("tie_cycles", 32'(k), 32'd11);
    drop_reqs();
    @(negedge CLK);
    #1;

    // Sub-word stores, wait states, word accesses.
    do_txn(1'b1, 1'b1, 2'd0, 32'h202, 32'h000000AB, 32'h11223344, 0, 1'b0, "sb");
    check_eq("i_rdata_held", i_rdata, 32'h0BADF00D);
    do_txn(1'b1, 1'b1, 2'd1, 32'h206, 32'h0000BEEF, 32'hCAFEF00D, 3, 1'b0, "sh_wait");
    do_txn(1'b1, 1'b1, 2'd2, 32'h40C, 32'hDEADBEEF, 32'h0, 1, 1'b0, "sw_wait");
    do_txn(1'b1, 1'b0, 2'd2, 32'h40D, 32'h0, 32'h12345678, 2, 1'b0, "lw_wait");
    do_txn(1'b0, 1'b0, 2'd0, 32'h80, 32'h0, 32'h00A00113, 3, 1'b0, "fetch_wait");
    for (int i = 0; i < 8; i++) begin
      rsz   = 2'($urandom_range(0, 1));
      raddr = $urandom & 32'h0000FFFF;
      do_txn(1'b1, 1'b1, rsz, raddr, $urandom, $urandom, $urandom_range(0, 2), 1'b0, "rmw_rand");
    end

    // Watchdog aborts: data read, then sub-word store aborted in its read phase.
    do_txn(1'b1, 1'b0, 2'd2, 32'h500, 32'h0, 32'hFFFFFFFF, 0, 1'b1, "timeout_rd");
    check_eq("timeout_err_set", {31'b0, timeout_err}, 32'h1);
    do_txn(1'b1, 1'b1, 2'd0, 32'h601, 32'h000000CC, 32'hFFFFFFFF, 0, 1'b1, "timeout_rmw");
    do_txn(1'b0, 1'b0, 2'd0, 32'h104, 32'h0, 32'h13579BDF, 1, 1'b0, "fetch_after_to");
    check_eq("timeout_err_sticky", {31'b0, timeout_err}, 32'h1);

    // Reset while the write phase of a sub-word store is stalled.
    cfg_wait = 2;
    ramload  = 32'h01020304;
    exp_addr = 32'h700;
    d_wen    = 1'b1;
    d_size   = 2'd0;
    d_addr   = 32'h701;
    d_wdata  = 32'h77;
    k        = 0;
    while (Wen !== 1'b1 && k < 20) begin
      @(negedge CLK);
      #1;
      k++;
    end
    check_eq("midrst_reached_wr", {31'b0, Wen}, 32'h1);
    nRST = 1'b0;
    @(negedge CLK);
    check_eq("midrst_Wen", {31'b0, Wen}, 32'h0);
    check_eq("midrst_d_ready", {31'b0, d_ready}, 32'h0);
    check_eq("midrst_ramaddr", ramaddr, 32'h0);
    check_eq("midrst_timeout_err", {31'b0, timeout_err}, 32'h0);
    #1;
    drop_reqs();
    @(negedge CLK);
    #1;
    nRST = 1'b1;
    do_txn(1'b0, 1'b0, 2'd0, 32'h208, 32'h0, 32'h02468ACE, 0, 1'b0, "fetch_after_midrst");

    repeat (3) @(negedge CLK);
    check_eq("rdy_q_drained", 32'(rdy_q.size()), 32'h0);
    check_eq("wr_q_drained", 32'(wr_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hung expected finish");
    $fatal(1);
  end

endmodule
